// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow, asynchronous input in system clock cycles.
// Supports single-shot and continuous measurement, with a timeout for a dead input.
module clk_period_meter #(
    parameter int CNT_W   = 27,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] period_next;
    logic [CNT_W-1:0] high_next;
    logic             valid_next;
    logic             timeout_next;

    // Both edges see the same synchronizer lag, so measured widths are exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            period    <= period_next;
            high_time <= high_next;
            valid     <= valid_next;
            timeout   <= timeout_next;
        end
    end

    // A rise always wins over the timeout check in the same cycle.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        period_next  = period;
        high_next    = high_time;
        valid_next   = 1'b0;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_next   = ONE_CNT;
                    state_next = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    cnt_next   = ONE_CNT;
                    state_next = MEASURE;
                end else if (cnt == TIMEOUT_CNT) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt + ONE_CNT;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_next = cnt;
                    valid_next  = 1'b1;
                    if (cont) begin
                        cnt_next = ONE_CNT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (fall) begin
                    high_next = cnt;
                    cnt_next  = cnt + ONE_CNT;
                end else if (cnt == TIMEOUT_CNT) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt + ONE_CNT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with TIMEOUT=50; a generator drives sig_in
// synchronously to clk and each scenario task checks its own results.
module tb_clk_period_meter;

    localparam int CNT_W   = 27;
    localparam int TIMEOUT = 50;

    logic             clk;
    logic             rst;
    logic             sig_in;
    logic             start;
    logic             cont;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             busy;
    logic             timeout;

    int checks   = 0;
    int failures = 0;

    int gen_mode   = 0;
    int req_period = 10;
    int req_high   = 4;
    int cur_period = 10;
    int cur_high   = 4;
    int phase      = 1000000;

    clk_period_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .start    (start),
        .cont     (cont),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: stuck low, 1: stuck high, 2: periodic with new settings taken at each rise
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_mode == 2) begin
                if (phase + 1 >= cur_period) begin
                    phase      = 0;
                    cur_period = req_period;
                    cur_high   = req_high;
                end else begin
                    phase = phase + 1;
                end
                sig_in = (phase < cur_high);
            end else begin
                phase  = 1000000;
                sig_in = (gen_mode == 1);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic start_at_rise(output bit found);
        bit prev;
        found = 1'b0;
        prev  = sig_in;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (sig_in && !prev) begin
                found = 1'b1;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            prev = sig_in;
        end
    endtask

    task automatic wait_out(input int budget, output bit got_valid, output bit got_timeout,
                            output int cycles);
        got_valid   = 1'b0;
        got_timeout = 1'b0;
        cycles      = 0;
        while (!got_valid && !got_timeout && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (valid)   got_valid   = 1'b1;
            if (timeout) got_timeout = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        cont  = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (period !== '0) begin failures++; $display("[TB] FAIL reset_period got=%0d want=0", period); end
        checks++; if (high_time !== '0) begin failures++; $display("[TB] FAIL reset_high got=%0d want=0", high_time); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout got=%b want=0", timeout); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit gv, gt;
        int n, extra;
        req_period = 10;
        req_high   = 4;
        gen_mode   = 2;
        extra      = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid || busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL idle_ignores_edges got=%0d want=0", extra); end
        pulse_start();
        wait_out(60, gv, gt, n);
        checks++; if (gv !== 1'b1 || gt !== 1'b0) begin failures++; $display("[TB] FAIL single_valid got_valid=%b got_timeout=%b want 1/0", gv, gt); end
        checks++; if (period !== 27'd10) begin failures++; $display("[TB] FAIL single_period got=%0d want=10", period); end
        checks++; if (high_time !== 27'd4) begin failures++; $display("[TB] FAIL single_high got=%0d want=4", high_time); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy got=%b want=0", busy); end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_width got=%b want=0", valid); end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL single_extra_valid got=%0d want=0", extra); end
    endtask

    task automatic test_continuous();
        bit gv, gt;
        int n;
        int exp_p [4] = '{10, 10, 16, 16};
        int exp_h [4] = '{4, 4, 8, 8};
        bit exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        cont = 1'b1;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_out(60, gv, gt, n);
            checks++; if (gv !== 1'b1 || gt !== 1'b0) begin failures++; $display("[TB] FAIL cont_valid_%0d got_valid=%b got_timeout=%b want 1/0", k, gv, gt); end
            checks++; if (period !== CNT_W'(exp_p[k])) begin failures++; $display("[TB] FAIL cont_period_%0d got=%0d want=%0d", k, period, exp_p[k]); end
            checks++; if (high_time !== CNT_W'(exp_h[k])) begin failures++; $display("[TB] FAIL cont_high_%0d got=%0d want=%0d", k, high_time, exp_h[k]); end
            checks++; if (busy !== exp_b[k]) begin failures++; $display("[TB] FAIL cont_busy_%0d got=%b want=%b", k, busy, exp_b[k]); end
            if (k == 0) begin
                req_period = 16;
                req_high   = 8;
            end
            if (k == 2) cont = 1'b0;
        end
    endtask

    task automatic test_timeout();
        bit gv, gt;
        int n;
        gen_mode = 0;
        repeat (5) @(negedge clk);
        pulse_start();
        wait_out(80, gv, gt, n);
        checks++; if (gt !== 1'b1 || gv !== 1'b0) begin failures++; $display("[TB] FAIL arm_timeout got_timeout=%b got_valid=%b want 1/0", gt, gv); end
        checks++; if (n + 1 !== 51) begin failures++; $display("[TB] FAIL arm_timeout_latency got=%0d want=51", n + 1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL arm_timeout_busy got=%b want=0", busy); end
        checks++; if (period !== 27'd16 || high_time !== 27'd8) begin failures++; $display("[TB] FAIL arm_timeout_hold got=%0d/%0d want=16/8", period, high_time); end
        @(negedge clk);
        checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL arm_timeout_width got=%b want=0", timeout); end
        pulse_start();
        gen_mode = 1;
        wait_out(100, gv, gt, n);
        checks++; if (gt !== 1'b1 || gv !== 1'b0) begin failures++; $display("[TB] FAIL meas_timeout got_timeout=%b got_valid=%b want 1/0", gt, gv); end
        checks++; if (n < 50) begin failures++; $display("[TB] FAIL meas_timeout_latency got=%0d want>=50", n); end
        checks++; if (period !== 27'd16 || high_time !== 27'd8) begin failures++; $display("[TB] FAIL meas_timeout_hold got=%0d/%0d want=16/8", period, high_time); end
        gen_mode = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_busy_restart_and_abort();
        bit gv, gt, found;
        int n, extra;
        req_period = 10;
        req_high   = 4;
        gen_mode   = 2;
        repeat (25) @(negedge clk);
        pulse_start();
        repeat (2) @(negedge clk);
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_out(60, gv, gt, n);
        checks++; if (gv !== 1'b1) begin failures++; $display("[TB] FAIL restart_valid got=%b want=1", gv); end
        checks++; if (period !== 27'd10 || high_time !== 27'd4) begin failures++; $display("[TB] FAIL restart_result got=%0d/%0d want=10/4", period, high_time); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL restart_busy got=%b want=0", busy); end
        req_period = 40;
        req_high   = 10;
        repeat (50) @(negedge clk);
        start_at_rise(found);
        checks++; if (!found) begin failures++; $display("[TB] FAIL abort_sync got=0 want=1"); end
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before got=%b want=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (period !== '0 || high_time !== '0) begin failures++; $display("[TB] FAIL abort_values got=%0d/%0d want=0/0", period, high_time); end
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("[TB] FAIL abort_flags got busy=%b valid=%b timeout=%b want 0/0/0", busy, valid, timeout); end
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (valid || timeout || busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL abort_quiet got=%0d want=0", extra); end
    endtask

    task automatic test_divider();
        bit gv, gt;
        int n;
        req_period = 10;
        req_high   = 5;
        repeat (50) @(negedge clk);
        cont = 1'b1;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_out(60, gv, gt, n);
            checks++; if (gv !== 1'b1) begin failures++; $display("[TB] FAIL div_valid_%0d got=%b want=1", k, gv); end
            checks++; if (period !== 27'd10 || high_time !== 27'd5) begin failures++; $display("[TB] FAIL div_result_%0d got=%0d/%0d want=10/5", k, period, high_time); end
        end
        cont = 1'b0;
        wait_out(60, gv, gt, n);
        checks++; if (gv !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL div_stop got_valid=%b busy=%b want 1/0", gv, busy); end
    endtask

    task automatic test_boundary();
        bit gv, gt, found;
        int n;
        req_period = 50;
        req_high   = 20;
        repeat (60) @(negedge clk);
        start_at_rise(found);
        checks++; if (!found) begin failures++; $display("[TB] FAIL p50_sync got=0 want=1"); end
        wait_out(100, gv, gt, n);
        checks++; if (gv !== 1'b1 || gt !== 1'b0) begin failures++; $display("[TB] FAIL p50_valid got_valid=%b got_timeout=%b want 1/0", gv, gt); end
        checks++; if (period !== 27'd50 || high_time !== 27'd20) begin failures++; $display("[TB] FAIL p50_result got=%0d/%0d want=50/20", period, high_time); end
        req_period = 51;
        repeat (60) @(negedge clk);
        start_at_rise(found);
        checks++; if (!found) begin failures++; $display("[TB] FAIL p51_sync got=0 want=1"); end
        wait_out(100, gv, gt, n);
        checks++; if (gt !== 1'b1 || gv !== 1'b0) begin failures++; $display("[TB] FAIL p51_timeout got_timeout=%b got_valid=%b want 1/0", gt, gv); end
        checks++; if (period !== 27'd50 || high_time !== 27'd20) begin failures++; $display("[TB] FAIL p51_hold got=%0d/%0d want=50/20", period, high_time); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_timeout();
        test_busy_restart_and_abort();
        test_divider();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
